// File: rtl/stream_run_ctrl_if.sv
// Stream-side handshake bundle between the run controller and the bench
// plumbing. Controller drives the valid gate and the sink ready; the
// surrounding logic reports the fires it observed on each side.
//   i_src_fire  : source valid&ready seen this cycle
//   i_snk_fire  : sink valid&ready seen this cycle
//   o_src_en    : source valid gate
//   o_snk_ready : ready presented to the DUT output
interface stream_run_ctrl_if;
    logic i_src_fire;
    logic i_snk_fire;
    logic o_src_en;
    logic o_snk_ready;

    modport master (
        input  i_src_fire,
        input  i_snk_fire,
        output o_src_en,
        output o_snk_ready
    );

    modport slave (
        output i_src_fire,
        output i_snk_fire,
        input  o_src_en,
        input  o_snk_ready
    );
endinterface

// File: rtl/stream_run_ctrl.sv
// Run controller: LFSR-throttled source/sink gating, beat counting,
// idle watchdog and done/timeout reporting around a DUT stream.
// Ports:
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_start               : start pulse (IDLE/DONE/TIMEOUT only)
//   i_seed[15:0]          : LFSR seed (0 -> 16'hACE1), upper bits unused
//   i_src_len, i_snk_len  : beats to issue / expect
//   i_valid_duty/ready    : stall weights, blocked on d/16 of cycles
//   io_strm               : fire inputs, src_en / snk_ready outputs
//   o_busy/done/timeout   : state flags
//   o_src_count/snk_count : beat counts of current or last run
module stream_run_ctrl #(
    parameter int COUNT_W    = 16,
    parameter int IDLE_LIMIT = 100
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [31:0]        i_seed,
    input  logic [COUNT_W-1:0] i_src_len,
    input  logic [COUNT_W-1:0] i_snk_len,
    input  logic [3:0]         i_valid_duty,
    input  logic [3:0]         i_ready_duty,
    stream_run_ctrl_if.master  io_strm,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_timeout,
    output logic [COUNT_W-1:0] o_src_count,
    output logic [COUNT_W-1:0] o_snk_count
);
    localparam int IDW = $clog2(IDLE_LIMIT + 1);
    localparam logic [IDW-1:0] IDLE_MAX = IDW'(IDLE_LIMIT);
    localparam logic [15:0] LFSR_INIT = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_TMO
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [15:0]        r_lfsr;
    logic [15:0]        r_seed;
    logic [15:0]        w_lfsr_nxt;
    logic               r_sv;
    logic               r_sr;
    logic [COUNT_W-1:0] r_src_len;
    logic [COUNT_W-1:0] r_snk_len;
    logic [COUNT_W-1:0] r_src_cnt;
    logic [COUNT_W-1:0] r_snk_cnt;
    logic [COUNT_W-1:0] w_src_cnt_nxt;
    logic [COUNT_W-1:0] w_snk_cnt_nxt;
    logic [IDW-1:0]     r_idle;
    logic [IDW-1:0]     w_idle_nxt;
    logic               w_run;
    logic               w_active;
    logic               w_launch;
    logic               w_fire;
    logic               w_wdog;
    logic               w_src_full;
    logic               w_snk_full;
    logic               w_unused;

    assign w_unused = ^i_seed[31:16];

    assign w_run    = (r_state == S_RUN);
    assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_launch = i_start && ((r_state == S_IDLE) ||
                                  (r_state == S_DONE) ||
                                  (r_state == S_TMO));

    // Galois right-shift: feed the dropped LSB back through the tap mask.
    assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^
                        (r_lfsr[0] ? LFSR_MASK : 16'h0000);

    // Counters saturate at the latched length; extra fires are dropped.
    assign w_src_cnt_nxt = r_src_cnt + COUNT_W'(w_run &&
                           io_strm.i_src_fire && (r_src_cnt < r_src_len));
    assign w_snk_cnt_nxt = r_snk_cnt + COUNT_W'(w_active &&
                           io_strm.i_snk_fire && (r_snk_cnt < r_snk_len));

    assign w_src_full = (w_src_cnt_nxt >= r_src_len);
    assign w_snk_full = (w_snk_cnt_nxt >= r_snk_len);

    // Source fires in DRAIN are ignored entirely, watchdog included.
    assign w_fire = (w_run && io_strm.i_src_fire) ||
                    (w_active && io_strm.i_snk_fire);

    assign w_idle_nxt = w_fire ? '0 : r_idle + IDW'(1);

    // A fire this cycle always keeps the run alive, so only a fireless
    // cycle can trip the watchdog ahead of a completion.
    assign w_wdog = w_active && !w_fire && (w_idle_nxt == IDLE_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE, S_DONE, S_TMO: begin
                if (i_start) begin
                    w_state_nxt = S_SEED;
                end
            end
            S_SEED: begin
                if ((r_src_len == '0) && (r_snk_len == '0)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_wdog) begin
                    w_state_nxt = S_TMO;
                end else if (w_src_full) begin
                    w_state_nxt = w_snk_full ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_wdog) begin
                    w_state_nxt = S_TMO;
                end else if (w_snk_full) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr    <= LFSR_INIT;
            r_seed    <= '0;
            r_sv      <= 1'b1;
            r_sr      <= 1'b1;
            r_src_len <= '0;
            r_snk_len <= '0;
            r_src_cnt <= '0;
            r_snk_cnt <= '0;
            r_idle    <= '0;
        end else begin
            if (w_launch) begin
                r_src_len <= i_src_len;
                r_snk_len <= i_snk_len;
                r_seed    <= i_seed[15:0];
                r_src_cnt <= '0;
                r_snk_cnt <= '0;
                r_idle    <= '0;
            end
            if (r_state == S_SEED) begin
                r_lfsr <= (r_seed == 16'h0000) ? LFSR_INIT : r_seed;
                r_sv   <= 1'b1;
                r_sr   <= 1'b1;
            end
            if (w_active) begin
                r_lfsr    <= w_lfsr_nxt;
                r_sv      <= (w_lfsr_nxt[3:0] < i_valid_duty);
                r_sr      <= (w_lfsr_nxt[7:4] < i_ready_duty);
                r_src_cnt <= w_src_cnt_nxt;
                r_snk_cnt <= w_snk_cnt_nxt;
                r_idle    <= w_idle_nxt;
            end
        end
    end

    always_comb begin
        o_busy      = (r_state == S_SEED) || w_active;
        o_done      = (r_state == S_DONE);
        o_timeout   = (r_state == S_TMO);
        o_src_count = r_src_cnt;
        o_snk_count = r_snk_cnt;
        io_strm.o_src_en    = w_run && !r_sv && (r_src_cnt < r_src_len);
        io_strm.o_snk_ready = w_active && !r_sr;
    end
endmodule

// File: doc/stream_run_ctrl.md
# stream_run_ctrl

Run controller for one memory-backed stimulus source and one capture sink around a DUT stream interface. On `i_start` it does four things:
- seeds a 16-bit LFSR and uses it to throttle source valid and sink ready at programmable stall rates;
- counts handshakes on both sides;
- runs an idle watchdog;
- reports done or timeout.

It replaces the free-running random valid/ready and `$finish` logic in generated top-level benches with one sequenced, reusable block.

## Interface
Parameters:
- `COUNT_W`, 16: width of beat counters and length inputs.
- `IDLE_LIMIT`, 100: consecutive cycles with no fire on either side before timeout (≥1).

Ports:
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  start pulse; honoured only in IDLE, DONE or TIMEOUT.
- `i_seed`  in  32  LFSR seed; only `[15:0]` is used; sampled with `i_start`.
- `i_src_len`  in  COUNT_W  source beats to issue; sampled with `i_start`.
- `i_snk_len`  in  COUNT_W  sink beats expected; sampled with `i_start`.
- `i_valid_duty`  in  4  source stall weight d: the source is blocked on d/16 of cycles; 0 means never blocked.
- `i_ready_duty`  in  4  sink stall weight, same encoding as `i_valid_duty`.
- `i_src_fire`  in  1  source valid&ready observed this cycle.
- `i_snk_fire`  in  1  sink valid&ready observed this cycle.
- `o_src_en`  out  1  source valid gate.
- `o_snk_ready`  out  1  ready driven to the DUT output.
- `o_busy`  out  1  state is SEED, RUN or DRAIN.
- `o_done`  out  1  state is DONE.
- `o_timeout`  out  1  state is TIMEOUT.
- `o_src_count`  out  COUNT_W  source beats counted in the current or last run.
- `o_snk_count`  out  COUNT_W  sink beats counted in the current or last run.

## Operation
- Reset values: state IDLE; LFSR 16'hACE1; all counters 0; stall bits 1; every output 0.
- LFSR: Galois, polynomial x^16+x^14+x^13+x^11+1, mask 16'hB400. Shifts right by one each cycle in RUN/DRAIN and holds otherwise. A seed of 0 is replaced by 16'hACE1.
- Stall bits, registered each LFSR step:
  - `sv <= (lfsr_next[3:0] < i_valid_duty)`
  - `sr <= (lfsr_next[7:4] < i_ready_duty)`
- Gate outputs, combinational decode of registered values:
  - `o_src_en = RUN && !sv && (src_count < src_len)`
  - `o_snk_ready = (RUN||DRAIN) && !sr`
- States:
  - IDLE: on `i_start`, latch lengths and seed, clear counters and idle counter, go to SEED.
  - SEED: load LFSR from the seed, set sv=sr=1, go to RUN. If both lengths are 0, go to DONE instead.
  - RUN: count `i_src_fire` and `i_snk_fire`. When `src_count` reaches `src_len` (including the update this cycle), go to DRAIN. If `snk_count` also reaches `snk_len` the same cycle, go directly to DONE.
  - DRAIN: count `i_snk_fire` only. Go to DONE when `snk_count` reaches `snk_len`.
  - DONE and TIMEOUT: hold counters and flags. `i_start` re-enters SEED via the IDLE actions.
- Counting rules:
  - Fires are counted only in RUN/DRAIN.
  - Each counter saturates at its latched length; extra fires are ignored.
  - `i_src_fire` in DRAIN is ignored.
- Watchdog:
  - The idle counter increments every RUN/DRAIN cycle with neither fire, and clears on any fire.
  - When it reaches `IDLE_LIMIT`, go to TIMEOUT. Timeout takes priority over a same-cycle completion only if no fire occurred that cycle.
  - Counter width is `$clog2(IDLE_LIMIT+1)`.
- `i_start` while busy is ignored; latched lengths never change mid-run.
- Asserting `i_rst_n` low mid-run immediately forces all reset values, including `o_src_en`=0 and `o_snk_ready`=0.

## Timing
- `i_start` high in cycle 0 (IDLE): SEED in cycle 1, `o_busy`=1 in cycle 1, RUN in cycle 2.
- `o_src_en` and `o_snk_ready` are 0 in cycle 2, because sv=sr=1 after SEED. The earliest assertion is cycle 3.
- The fire that completes the last required beat is counted at the clock edge that consumes it. `o_done` rises the following cycle; `o_busy` falls the same cycle.
- `o_src_en` drops combinationally in the cycle after the final source fire, so no extra beat is issued.
- Timeout: after the last fire at edge t, `o_timeout`=1 at t+IDLE_LIMIT.

## Test plan
- Duty 0/0, src_len=snk_len=8, DUT pass-through with 1-cycle latency, `i_start` at cycle 0: `o_src_en` high cycles 3–10, 8 fires each side, `o_done`=1 at cycle 12, counts 8/8.
- Duty 8/8, seed 32'h1234, lengths 64: both counts reach 64, `o_done` set, no timeout. The sv/sr sequences match a reference LFSR model bit-exactly.
- src_len=4, snk_len=5, sink fires only 4 times: DRAIN is held, then `o_timeout`=1 exactly 100 cycles after the 4th sink fire; counts read 4/4.
- Both lengths 0: SEED goes directly to DONE; `o_done` at cycle 2; `o_src_en` never asserts.
- `i_start` pulsed mid-RUN is ignored. Then `i_rst_n` low mid-RUN: all outputs 0 asynchronously. After release, a new `i_start` runs cleanly with counts from 0.
- Extra `i_src_fire` pulses after src_len is reached, and `i_snk_fire` in DONE: counts stay saturated/held and the state is unchanged.
